// File: rtl/prog_load_ctrl_pkg.sv
// Shared types and defaults for the UART program-load sequencer.
package prog_load_ctrl_pkg;

  localparam int unsigned PL_ADDR_W      = 14;
  localparam int unsigned PL_DATA_W      = 32;
  localparam int unsigned PL_TIMEOUT_CYC = 24'hFFFFFF;
  localparam int unsigned PL_RELEASE_CYC = 16;

  // Idle timer must hold TIMEOUT_CYC-1; release timer must hold RELEASE_CYC-1.
  localparam int unsigned PL_TMR_W = 24;
  localparam int unsigned PL_REL_W = 16;
  localparam int unsigned PL_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RELEASE = 3'd4
  } pl_state_e;

endpackage

// File: rtl/prog_load_ctrl.sv
// UART program-load sequencer: owns loader/CPU resets and the shared
// imem/dmem write port while a program image is downloaded.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | CPU runs, loader held in reset, CPU owns the dmem write port
//  ARM     | one cycle: release loader, hold CPU, clear count/error/timer
//  LOAD    | loader writes forwarded combinationally to imem or dmem
//  DRAIN   | one cycle: no writes, loader back into reset
//  RELEASE | CPU still held for RELEASE_CYC cycles, then back to IDLE
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = PL_ADDR_W,
  parameter int unsigned DATA_W      = PL_DATA_W,
  parameter int unsigned TIMEOUT_CYC = PL_TIMEOUT_CYC,
  parameter int unsigned RELEASE_CYC = PL_RELEASE_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_pg,
  input  logic                upg_done,
  input  logic                upg_wen,
  input  logic [ADDR_W:0]     upg_adr,
  input  logic [DATA_W-1:0]   upg_dat,
  input  logic                cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_adr,
  input  logic [DATA_W-1:0]   cpu_dat,
  output logic                upg_rst,
  output logic                cpu_rst,
  output logic                imem_wen,
  output logic                dmem_wen,
  output logic [ADDR_W-1:0]   mem_adr,
  output logic [DATA_W-1:0]   mem_dat,
  output logic [PL_CNT_W-1:0] word_cnt,
  output logic                busy,
  output logic                err_timeout
);

  localparam logic [PL_TMR_W-1:0] IDLE_TC = PL_TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [PL_REL_W-1:0] REL_TC  = PL_REL_W'(RELEASE_CYC - 1);

  pl_state_e             state_q, state_d;
  logic                  start_pg_q;
  logic                  start_edge;
  logic                  timeout_hit;
  logic                  imem_wen_raw, dmem_wen_raw;
  logic [PL_TMR_W-1:0]   idle_tmr_q;
  logic [PL_REL_W-1:0]   rel_tmr_q;

  assign start_edge = start_pg & ~start_pg_q;

  // State register, start-edge history, word counter, timers and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_pg_q  <= 1'b0;
      word_cnt    <= '0;
      err_timeout <= 1'b0;
      idle_tmr_q  <= '0;
      rel_tmr_q   <= '0;
    end else begin
      state_q    <= state_d;
      start_pg_q <= start_pg;
      case (state_q)
        ST_ARM: begin
          word_cnt    <= '0;
          err_timeout <= 1'b0;
          idle_tmr_q  <= '0;
        end
        ST_LOAD: begin
          if (upg_wen) begin
            idle_tmr_q <= '0;
            if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
          end else begin
            idle_tmr_q <= idle_tmr_q + 1'b1;
          end
          if (timeout_hit) err_timeout <= 1'b1;
        end
        ST_DRAIN:   rel_tmr_q <= '0;
        ST_RELEASE: rel_tmr_q <= rel_tmr_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Next state, reset controls and the write-path mux (loader vs CPU).
  always_comb begin
    state_d      = state_q;
    upg_rst      = 1'b1;
    cpu_rst      = 1'b1;
    busy         = 1'b1;
    timeout_hit  = 1'b0;
    imem_wen_raw = 1'b0;
    dmem_wen_raw = 1'b0;
    mem_adr      = cpu_adr;
    mem_dat      = cpu_dat;
    case (state_q)
      ST_IDLE: begin
        cpu_rst      = 1'b0;
        busy         = 1'b0;
        dmem_wen_raw = cpu_wen;
        if (start_edge) state_d = ST_ARM;
      end
      ST_ARM: begin
        upg_rst = 1'b0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        upg_rst = 1'b0;
        mem_adr = upg_adr[ADDR_W-1:0];
        mem_dat = upg_dat;
        if (upg_wen) begin
          imem_wen_raw = ~upg_adr[ADDR_W];
          dmem_wen_raw = upg_adr[ADDR_W];
        end
        if (upg_done) begin
          state_d = ST_DRAIN;
        end else if (!upg_wen && (idle_tmr_q == IDLE_TC)) begin
          timeout_hit = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (rel_tmr_q == REL_TC) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A write presented in the same cycle as reset must not reach memory.
    imem_wen = imem_wen_raw & ~rst;
    dmem_wen = dmem_wen_raw & ~rst;
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: directed sequences plus randomized
// loads scored against an expected-write queue and timing rules.
module tb_prog_load_ctrl;
  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 8;
  localparam int RELEASE_CYC = 16;

  typedef struct packed {
    logic              is_d;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst, start_pg, upg_done, upg_wen, cpu_wen;
  logic [ADDR_W:0]   upg_adr;
  logic [DATA_W-1:0] upg_dat, cpu_dat;
  logic [ADDR_W-1:0] cpu_adr;
  logic              upg_rst, cpu_rst, imem_wen, dmem_wen, busy, err_timeout;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_dat;
  logic [15:0]       word_cnt;

  int  checks = 0;
  int  failures = 0;
  int  exp_cnt = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  always #5 clk = ~clk;

  prog_load_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .RELEASE_CYC(RELEASE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg), .upg_done(upg_done),
    .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat),
    .cpu_wen(cpu_wen), .cpu_adr(cpu_adr), .cpu_dat(cpu_dat),
    .upg_rst(upg_rst), .cpu_rst(cpu_rst), .imem_wen(imem_wen),
    .dmem_wen(dmem_wen), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .word_cnt(word_cnt), .busy(busy), .err_timeout(err_timeout)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every memory write the DUT issues is recorded; both enables together is an error.
  always @(negedge clk) begin
    if (imem_wen === 1'b1 || dmem_wen === 1'b1) begin
      check_val("wen_excl", {63'b0, imem_wen & dmem_wen}, 64'd0);
      obs_q.push_back(wr_t'{is_d: dmem_wen, adr: mem_adr, dat: mem_dat});
    end
  end

  task automatic compare_writes(input string tag);
    check_val({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_val({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic start_load(input bit done_in_arm);
    start_pg = 1'b1;
    tick();
    start_pg = 1'b0;
    upg_done = done_in_arm;
    @(negedge clk);
    check_val("arm_busy", {63'b0, busy}, 64'd1);
    check_val("arm_cpu_rst", {63'b0, cpu_rst}, 64'd1);
    check_val("arm_upg_rst", {63'b0, upg_rst}, 64'd0);
    tick();
    upg_done = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic ld_write(input logic [ADDR_W:0] adr, input logic [DATA_W-1:0] dat, input bit done);
    bit to_d;
    to_d = adr[ADDR_W];
    upg_wen = 1'b1;
    upg_adr = adr;
    upg_dat = dat;
    upg_done = done;
    @(negedge clk);
    check_val("ld_upg_rst", {63'b0, upg_rst}, 64'd0);
    check_val("ld_cpu_rst", {63'b0, cpu_rst}, 64'd1);
    check_val("ld_imem_wen", {63'b0, imem_wen}, {63'b0, !to_d});
    check_val("ld_dmem_wen", {63'b0, dmem_wen}, {63'b0, to_d});
    check_val("ld_mem_adr", 64'(mem_adr), 64'(adr[ADDR_W-1:0]));
    check_val("ld_mem_dat", 64'(mem_dat), 64'(dat));
    exp_q.push_back(wr_t'{is_d: to_d, adr: adr[ADDR_W-1:0], dat: dat});
    if (exp_cnt < 65535) exp_cnt++;
    tick();
    upg_wen = 1'b0;
    upg_done = 1'b0;
  endtask

  task automatic idle_gap(input int n, input bit cpu_noise);
    for (int i = 0; i < n; i++) begin
      cpu_wen = cpu_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_adr = ADDR_W'($urandom);
      cpu_dat = $urandom;
      tick();
    end
    cpu_wen = 1'b0;
  endtask

  // cpu_rst must drop RELEASE_CYC+2 clocks after upg_done is raised.
  task automatic finish_load(input string tag, input bit with_write,
                             input logic [ADDR_W:0] adr, input logic [DATA_W-1:0] dat);
    int k;
    if (with_write) ld_write(adr, dat, 1'b1);
    else begin
      upg_done = 1'b1;
      tick();
      upg_done = 1'b0;
    end
    k = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_rst === 1'b0) break;
      tick();
      k++;
    end
    check_val({tag, "_rel_cycles"}, 64'(k), 64'(RELEASE_CYC + 2));
    check_val({tag, "_idle_busy"}, {63'b0, busy}, 64'd0);
    check_val({tag, "_idle_upg_rst"}, {63'b0, upg_rst}, 64'd1);
    check_val({tag, "_word_cnt"}, 64'(word_cnt), 64'(exp_cnt));
    tick();
    compare_writes(tag);
  endtask

  initial begin
    int k, nwr;
    logic [ADDR_W:0]   a;
    logic [DATA_W-1:0] d;

    rst = 1'b1; start_pg = 1'b0; upg_done = 1'b0; upg_wen = 1'b0;
    upg_adr = '0; upg_dat = '0; cpu_wen = 1'b0; cpu_adr = '0; cpu_dat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_upg_rst", {63'b0, upg_rst}, 64'd1);
    check_val("rst_cpu_rst", {63'b0, cpu_rst}, 64'd0);
    check_val("rst_busy", {63'b0, busy}, 64'd0);
    check_val("rst_word_cnt", 64'(word_cnt), 64'd0);
    check_val("rst_err", {63'b0, err_timeout}, 64'd0);
    tick();

    // Four imem words then a separate upg_done.
    start_load(1'b0);
    for (int i = 0; i < 4; i++) ld_write(15'(i), $urandom, 1'b0);
    finish_load("imem4", 1'b0, '0, '0);

    // dmem routing, upg_done ignored in ARM, longest safe gap, write with done.
    start_load(1'b1);
    ld_write(15'h4010, 32'hDEADBEEF, 1'b0);
    idle_gap(TIMEOUT_CYC - 1, 1'b1);
    check_val("gap_no_timeout", {63'b0, err_timeout}, 64'd0);
    ld_write(15'h0123, $urandom, 1'b0);
    finish_load("done_wr", 1'b1, 15'h7FFF, 32'h0BADF00D);

    // Randomized loads, CPU writes attempted while held in reset.
    for (int it = 0; it < 6; it++) begin
      start_load(1'($urandom_range(0, 1)));
      nwr = $urandom_range(1, 8);
      for (int w = 0; w < nwr - 1; w++) begin
        idle_gap($urandom_range(0, 4), 1'b1);
        ld_write(15'($urandom), $urandom, 1'b0);
      end
      idle_gap($urandom_range(0, 4), 1'b1);
      a = 15'($urandom);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) finish_load("rand", 1'b1, a, d);
      else begin
        ld_write(a, d, 1'b0);
        finish_load("rand", 1'b0, '0, '0);
      end
    end

    // Timeout with no writes, sticky until the next ARM.
    start_load(1'b0);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) break;
      tick();
      k++;
    end
    check_val("to_cycles", 64'(k), 64'(TIMEOUT_CYC));
    k = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b0) break;
      tick();
      k++;
    end
    check_val("to_back_idle", 64'(k), 64'(RELEASE_CYC + 1));
    check_val("to_err_sticky", {63'b0, err_timeout}, 64'd1);
    check_val("to_word_cnt", 64'(word_cnt), 64'd0);
    check_val("to_cpu_rst", {63'b0, cpu_rst}, 64'd0);
    tick();
    start_load(1'b0);
    @(negedge clk);
    check_val("to_err_cleared", {63'b0, err_timeout}, 64'd0);
    tick();
    finish_load("to_after", 1'b1, 15'h4001, 32'h12345678);

    // Start edge in RELEASE is ignored.
    start_load(1'b0);
    ld_write(15'h0042, $urandom, 1'b0);
    upg_done = 1'b1;
    tick();
    upg_done = 1'b0;
    idle_gap(4, 1'b0);
    start_pg = 1'b1;
    tick();
    start_pg = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
    idle_gap(5, 1'b0);
    @(negedge clk);
    check_val("rel_start_ignored", {63'b0, busy}, 64'd0);
    check_val("rel_start_cpu_rst", {63'b0, cpu_rst}, 64'd0);
    tick();
    compare_writes("rel_start");

    // Reset mid-LOAD with a write pending.
    start_load(1'b0);
    ld_write(15'($urandom), $urandom, 1'b0);
    ld_write(15'($urandom), $urandom, 1'b0);
    rst = 1'b1;
    upg_wen = 1'b1;
    upg_adr = 15'($urandom);
    upg_dat = $urandom;
    @(negedge clk);
    check_val("rst_ld_no_wen", {62'b0, imem_wen, dmem_wen}, 64'd0);
    tick();
    rst = 1'b0;
    upg_wen = 1'b0;
    @(negedge clk);
    check_val("rst_ld_busy", {63'b0, busy}, 64'd0);
    check_val("rst_ld_cpu_rst", {63'b0, cpu_rst}, 64'd0);
    check_val("rst_ld_word_cnt", 64'(word_cnt), 64'd0);
    tick();

    // CPU owns dmem in IDLE.
    for (int i = 0; i < 3; i++) begin
      cpu_wen = 1'b1;
      cpu_adr = ADDR_W'($urandom);
      cpu_dat = $urandom;
      @(negedge clk);
      check_val("cpu_dmem_wen", {63'b0, dmem_wen}, 64'd1);
      check_val("cpu_imem_wen", {63'b0, imem_wen}, 64'd0);
      check_val("cpu_mem_adr", 64'(mem_adr), 64'(cpu_adr));
      check_val("cpu_mem_dat", 64'(mem_dat), 64'(cpu_dat));
      exp_q.push_back(wr_t'{is_d: 1'b1, adr: cpu_adr, dat: cpu_dat});
      tick();
    end
    cpu_wen = 1'b0;
    tick();
    compare_writes("rst_cpu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
